// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sram_port_arbiter_if
// | Request/response bundle between the lookup/fill requesters and one SRAM array.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface sram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 20,
  parameter int NUM_BLOCKS = 4
);
  logic [ADDR_WIDTH-1:0] i_rd_addr;
  logic                  i_rd_valid;
  logic                  o_rd_ready;
  logic [ADDR_WIDTH-1:0] i_wr_addr;
  logic [WORD_WIDTH-1:0] i_wr_data;
  logic [NUM_BLOCKS-1:0] i_wr_mask;
  logic                  i_wr_valid;
  logic                  o_wr_ready;
  logic                  i_miss_state;
  logic                  i_sram_halt;
  logic [ADDR_WIDTH-1:0] o_sram_addr;
  logic [WORD_WIDTH-1:0] o_sram_data;
  logic [NUM_BLOCKS-1:0] o_sram_mask;
  logic                  o_sram_wen;
  logic                  o_sram_valid;

  modport slave (
    input  i_rd_addr, i_rd_valid, i_wr_addr, i_wr_data, i_wr_mask, i_wr_valid,
    input  i_miss_state, i_sram_halt,
    output o_rd_ready, o_wr_ready,
    output o_sram_addr, o_sram_data, o_sram_mask, o_sram_wen, o_sram_valid
  );

  modport master (
    output i_rd_addr, i_rd_valid, i_wr_addr, i_wr_data, i_wr_mask, i_wr_valid,
    output i_miss_state, i_sram_halt,
    input  o_rd_ready, o_wr_ready,
    input  o_sram_addr, o_sram_data, o_sram_mask, o_sram_wen, o_sram_valid
  );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | sram_port_arbiter
// | Shares one single-ported SRAM array between lookup reads and fill writes,
// | with a registered request stage. Optional grant statistics: SRAM_ARB_STATS_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_WIDTH    = 8,
  parameter int WORD_WIDTH    = 20,
  parameter int NUM_BLOCKS    = 4,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic               clk,
  input  logic               arst_n,
  sram_port_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]        o_rd_grant_cnt,
  output logic [15:0]        o_wr_grant_cnt
`endif
);

  localparam int                c_STREAK_W   = $clog2(MAX_RD_STREAK + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_RD_STREAK);

  typedef enum logic [0:0] {
    S_RD_PRI = 1'b0,
    S_WR_PRI = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_STREAK_W-1:0] r_streak;
  logic [c_STREAK_W-1:0] w_streak_nxt;
  logic                  w_rd_grant;
  logic                  w_wr_grant;

  logic [ADDR_WIDTH-1:0] r_sram_addr;
  logic [WORD_WIDTH-1:0] r_sram_data;
  logic [NUM_BLOCKS-1:0] r_sram_mask;
  logic                  r_sram_wen;
  logic                  r_sram_valid;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_RD_PRI;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // The streak compare uses the post-grant value so the write gets the very
  // next slot after MAX_RD_STREAK reads have been granted over it.
  always_comb begin
    w_rd_grant   = 1'b0;
    w_wr_grant   = 1'b0;
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    if (!bus.i_sram_halt) begin
      case (r_state)
        S_RD_PRI: begin
          w_rd_grant = bus.i_rd_valid;
          w_wr_grant = !bus.i_rd_valid && bus.i_wr_valid;
        end
        default: begin
          w_wr_grant = bus.i_wr_valid;
          w_rd_grant = !bus.i_wr_valid && bus.i_rd_valid;
        end
      endcase

      if (w_wr_grant || !bus.i_wr_valid) begin
        w_streak_nxt = '0;
      end else if (w_rd_grant && (r_streak != c_STREAK_MAX)) begin
        w_streak_nxt = r_streak + c_STREAK_W'(1);
      end

      case (r_state)
        S_RD_PRI: begin
          if (bus.i_miss_state || (bus.i_wr_valid && (w_streak_nxt == c_STREAK_MAX))) begin
            w_state_nxt = S_WR_PRI;
          end
        end
        default: begin
          if (!bus.i_miss_state && (w_wr_grant || !bus.i_wr_valid)) begin
            w_state_nxt = S_RD_PRI;
          end
        end
      endcase
    end
  end

  assign bus.o_rd_ready = w_rd_grant;
  assign bus.o_wr_ready = w_wr_grant;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_sram_addr  <= '0;
      r_sram_data  <= '0;
      r_sram_mask  <= '0;
      r_sram_wen   <= 1'b0;
      r_sram_valid <= 1'b0;
    end else if (!bus.i_sram_halt) begin
      if (w_rd_grant) begin
        r_sram_addr  <= bus.i_rd_addr;
        r_sram_data  <= '0;
        r_sram_mask  <= '1;
        r_sram_wen   <= 1'b0;
        r_sram_valid <= 1'b1;
      end else if (w_wr_grant) begin
        r_sram_addr  <= bus.i_wr_addr;
        r_sram_data  <= bus.i_wr_data;
        r_sram_mask  <= bus.i_wr_mask;
        r_sram_wen   <= 1'b1;
        r_sram_valid <= 1'b1;
      end else begin
        r_sram_valid <= 1'b0;
      end
    end
  end

  assign bus.o_sram_addr  = r_sram_addr;
  assign bus.o_sram_data  = r_sram_data;
  assign bus.o_sram_mask  = r_sram_mask;
  assign bus.o_sram_wen   = r_sram_wen;
  assign bus.o_sram_valid = r_sram_valid;

`ifdef SRAM_ARB_STATS_EN
  logic [7:0]  r_idle_cnt;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic        w_idle;

  assign w_idle = !bus.i_sram_halt && !bus.i_rd_valid && !bus.i_wr_valid;

  // A halted cycle breaks an idle run, so the flush needs 256 truly quiet cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_idle_cnt <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else if (w_idle) begin
      r_idle_cnt <= r_idle_cnt + 8'd1;
      if (r_idle_cnt == 8'hFF) begin
        r_rd_cnt <= '0;
        r_wr_cnt <= '0;
      end
    end else begin
      r_idle_cnt <= '0;
      if (w_rd_grant && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_wr_grant && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign o_rd_grant_cnt = r_rd_cnt;
  assign o_wr_grant_cnt = r_wr_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_sram_port_arbiter
// | Directed stimulus with a queue-based scoreboard on the registered SRAM port.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_sram_port_arbiter;
  localparam int AW = 8;
  localparam int WW = 20;
  localparam int NB = 4;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .NUM_BLOCKS(NB)) bus ();

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  sram_port_arbiter #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .NUM_BLOCKS(NB), .MAX_RD_STREAK(4)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
`ifdef SRAM_ARB_STATS_EN
    ,
    .o_rd_grant_cnt (rd_cnt),
    .o_wr_grant_cnt (wr_cnt)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic [NB-1:0] mask;
    logic          wen;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected output lands on the edge following the current negedge.
  task automatic push(input logic [AW-1:0] a, input logic [WW-1:0] d,
                      input logic [NB-1:0] m, input logic w);
    exp_t e;
    e.addr = a; e.data = d; e.mask = m; e.wen = w; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    logic h;
    exp_t e;
    cyc++;
    h = bus.i_sram_halt;
    #1;
    if (arst_n && !h) begin
      if (bus.o_sram_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got valid addr %0h wen %0b, required no output",
                   bus.o_sram_addr, bus.o_sram_wen);
        end else begin
          e = q.pop_front();
          chk("out_cycle", 32'(cyc), 32'(e.cyc));
          chk("out_addr",  32'(bus.o_sram_addr), 32'(e.addr));
          chk("out_data",  32'(bus.o_sram_data), 32'(e.data));
          chk("out_mask",  32'(bus.o_sram_mask), 32'(e.mask));
          chk("out_wen",   32'(bus.o_sram_wen),  32'(e.wen));
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_output: got valid=0 at cycle %0d, required addr %0h", cyc, e.addr);
      end
    end
  end

  logic pat_wr [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int ra;
    int wa;
    bus.i_rd_addr = '0; bus.i_rd_valid = 1'b0;
    bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_wr_mask = '0; bus.i_wr_valid = 1'b0;
    bus.i_miss_state = 1'b0; bus.i_sram_halt = 1'b0;

    // Reset values, then a reset landing while a write is on the SRAM port.
    @(negedge clk); #1;
    chk("rst_addr",  32'(bus.o_sram_addr), 32'h0);
    chk("rst_data",  32'(bus.o_sram_data), 32'h0);
    chk("rst_ctl",   32'({bus.o_sram_mask, bus.o_sram_wen, bus.o_sram_valid}), 32'h0);
    arst_n = 1'b1;
    @(negedge clk);
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 8'h33; bus.i_wr_data = 20'h12345; bus.i_wr_mask = 4'b0101;
    #1; chk("wr0_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b01));
    push(8'h33, 20'h12345, 4'b0101, 1'b1);
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    #1; chk("pre_rst_valid", 32'(bus.o_sram_valid), 32'h1);
    #1; arst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(bus.o_sram_addr), 32'h0);
    chk("arst_data", 32'(bus.o_sram_data), 32'h0);
    chk("arst_ctl",  32'({bus.o_sram_mask, bus.o_sram_wen, bus.o_sram_valid}), 32'h0);
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    bus.i_rd_valid = 1'b1; bus.i_rd_addr = 8'h12;
    #1; chk("rd12_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b10));
    push(8'h12, 20'h0, 4'hF, 1'b0);
    @(negedge clk); bus.i_rd_valid = 1'b0;

    // Lone read: one-cycle valid pulse with full mask.
    @(negedge clk);
    bus.i_rd_valid = 1'b1; bus.i_rd_addr = 8'h7F;
    #1; chk("rd7f_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b10));
    push(8'h7F, 20'h0, 4'hF, 1'b0);
    @(negedge clk); bus.i_rd_valid = 1'b0;
    #1; chk("rd7f_valid_on", 32'(bus.o_sram_valid), 32'h1);
    @(negedge clk);
    #1; chk("rd7f_valid_off", 32'(bus.o_sram_valid), 32'h0);

    // Both requesters saturated: four reads then one write, repeating.
    ra = 1; wa = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_rd_valid = 1'b1; bus.i_rd_addr = 8'(ra);
      bus.i_wr_valid = 1'b1; bus.i_wr_addr = 8'(8'h80 + wa);
      bus.i_wr_data = 20'(20'h00100 + wa); bus.i_wr_mask = 4'b1000;
      #1;
      if (pat_wr[i]) begin
        chk("pat_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b01));
        push(8'(8'h80 + wa), 20'(20'h00100 + wa), 4'b1000, 1'b1);
        wa++;
      end else begin
        chk("pat_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b10));
        push(8'(ra), 20'h0, 4'hF, 1'b0);
        ra++;
      end
    end

    // Miss handling: writes own the port until miss drops with the last write.
    @(negedge clk);
    bus.i_rd_valid = 1'b0; bus.i_wr_valid = 1'b0; bus.i_miss_state = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      bus.i_rd_valid = 1'b1; bus.i_rd_addr = 8'h30;
      bus.i_wr_valid = 1'b1; bus.i_wr_addr = 8'(8'h40 + j);
      bus.i_wr_data = 20'(20'h0A000 + j); bus.i_wr_mask = 4'b0010;
      bus.i_miss_state = (j != 3);
      #1; chk("miss_wr_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b01));
      push(8'(8'h40 + j), 20'(20'h0A000 + j), 4'b0010, 1'b1);
    end
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    #1; chk("miss_rd_resume", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b10));
    push(8'h30, 20'h0, 4'hF, 1'b0);

    // Halt for three edges with a write waiting; outputs keep the last read.
    @(negedge clk);
    bus.i_rd_addr = 8'h21;
    #1; chk("pre_halt_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b10));
    push(8'h21, 20'h0, 4'hF, 1'b0);
    @(negedge clk);
    bus.i_rd_valid = 1'b0; bus.i_sram_halt = 1'b1;
    bus.i_wr_valid = 1'b1; bus.i_wr_addr = 8'h55; bus.i_wr_data = 20'hABCDE; bus.i_wr_mask = 4'b0100;
    #1; chk("halt_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b00));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("halt_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b00));
      chk("halt_frozen_addr", 32'(bus.o_sram_addr), 32'h21);
      chk("halt_frozen_ctl", 32'({bus.o_sram_mask, bus.o_sram_wen, bus.o_sram_valid}), 32'({4'hF, 1'b0, 1'b1}));
    end
    bus.i_sram_halt = 1'b0;
    #1; chk("unhalt_wr_ready", 32'({bus.o_rd_ready, bus.o_wr_ready}), 32'(2'b01));
    push(8'h55, 20'hABCDE, 4'b0100, 1'b1);
    @(negedge clk);
    bus.i_wr_valid = 1'b0;

`ifdef SRAM_ARB_STATS_EN
    repeat (256) @(negedge clk);
    #1; chk("stats_flush0", 32'({rd_cnt, wr_cnt}), 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_rd_valid = 1'b1; bus.i_rd_addr = 8'(8'h60 + i);
      #1; push(8'(8'h60 + i), 20'h0, 4'hF, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.i_rd_valid = 1'b0;
      bus.i_wr_valid = 1'b1; bus.i_wr_addr = 8'(8'hA0 + i); bus.i_wr_data = 20'(i + 1); bus.i_wr_mask = 4'hF;
      #1; push(8'(8'hA0 + i), 20'(i + 1), 4'hF, 1'b1);
    end
    @(negedge clk);
    bus.i_wr_valid = 1'b0;
    #1;
    chk("stats_rd_cnt", 32'(rd_cnt), 32'd10);
    chk("stats_wr_cnt", 32'(wr_cnt), 32'd3);
    repeat (255) @(negedge clk);
    #1; chk("stats_idle255", 32'({rd_cnt, wr_cnt}), 32'h000A_0003);
    @(negedge clk);
    #1; chk("stats_idle256", 32'({rd_cnt, wr_cnt}), 32'h0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
